// File: rtl/magnitude_detect_if.sv
// Sample stream in, smoothed value and detection results out, for magnitude_detect.
// The master drives samples and thresholds; the slave is the detector.
interface magnitude_detect_if;
    logic        in_valid;
    logic [7:0]  mag;
    logic [7:0]  th_on;
    logic [7:0]  th_off;
    logic [7:0]  avg;
    logic        avg_valid;
    logic        detect;
    logic        det_start;
    logic [7:0]  peak;
    logic [15:0] event_count;

    modport master (
        output in_valid, mag, th_on, th_off,
        input  avg, avg_valid, detect, det_start, peak, event_count
    );

    modport slave (
        input  in_valid, mag, th_on, th_off,
        output avg, avg_valid, detect, det_start, peak, event_count
    );
endinterface

// File: rtl/magnitude_detect.sv
// Moving-average magnitude smoother followed by a hysteresis/hold signal-present detector.
// Define MAGNITUDE_DETECT_PEAK_EN to build the per-event peak tracker; otherwise peak reads 0.
module magnitude_detect #(
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    magnitude_detect_if.slave bus
);
    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int unsigned SW = 8 + AVG_LOG2;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    logic [7:0]    sample;
    logic [7:0]    win_q [N];
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;
    logic [7:0]    avg_q;
    logic          avg_valid_q;
    state_t        state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          detect_q;
    logic          det_start_q;
    logic [15:0]   event_count_q;

    // Negative samples carry no energy; modular add/sub keeps the running sum exact.
    always_comb begin
        sample = bus.mag[7] ? '0 : bus.mag;
        sum_d  = sum_q + SW'(sample) - SW'(win_q[N-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                for (int unsigned i = N - 1; i > 0; i--) begin
                    win_q[i] <= win_q[i-1];
                end
                win_q[0] <= sample;
                sum_q    <= sum_d;
                avg_q    <= 8'(sum_d >> AVG_LOG2);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            detect_q      <= 1'b0;
            det_start_q   <= 1'b0;
            event_count_q <= '0;
        end else begin
            det_start_q <= 1'b0;
            if (avg_valid_q) begin
                unique case (state_q)
                    IDLE: begin
                        if (avg_q >= bus.th_on) begin
                            state_q     <= ACTIVE;
                            detect_q    <= 1'b1;
                            det_start_q <= 1'b1;
                            if (event_count_q != '1) begin
                                event_count_q <= event_count_q + 16'd1;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (avg_q < bus.th_off) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= HOLD_LOAD;
                        end
                    end
                    HOLD: begin
                        // Re-crossing th_on continues the same event.
                        if (avg_q >= bus.th_on) begin
                            state_q <= ACTIVE;
                        end else if (hold_cnt_q == '0) begin
                            state_q  <= IDLE;
                            detect_q <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - HW'(1);
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        detect_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAGNITUDE_DETECT_PEAK_EN
    logic [7:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (avg_valid_q) begin
            if (state_q == IDLE) begin
                if (avg_q >= bus.th_on) begin
                    peak_q <= avg_q;
                end
            end else if (avg_q > peak_q) begin
                peak_q <= avg_q;
            end
        end
    end

    assign bus.peak = peak_q;
`else
    assign bus.peak = '0;
`endif

    assign bus.avg         = avg_q;
    assign bus.avg_valid   = avg_valid_q;
    assign bus.detect      = detect_q;
    assign bus.det_start   = det_start_q;
    assign bus.event_count = event_count_q;
endmodule
